// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces a stall request while busy and a one-cycle done pulse with HI/LO results.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall_req,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  logic [WIDTH-1:0] quot, rem_fin;

  // dvd_q doubles as the quotient register: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  always_comb begin
    rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = ~diff[WIDTH];
    quot    = {dvd_q[WIDTH-2:0], q_bit};
    rem_fin = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              lo_d    = '1;
              hi_d    = dividend;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_CALC;
              dvd_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
              dvs_d   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
              negq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              negr_d  = is_signed & dividend[WIDTH-1];
              cnt_d   = '0;
              rem_d   = '0;
            end
          end
        end
        S_CALC: begin
          rem_d = {1'b0, rem_fin};
          dvd_d = quot;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lo_d    = negq_q ? -quot : quot;
            hi_d    = negr_q ? -rem_fin : rem_fin;
            dbz_d   = 1'b0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall_req   = ~cancel & (((state_q == S_IDLE) & start) | (state_q == S_CALC));
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results and latency, plus
// hand-written cancel, reset and back-to-back sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        stall_req, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .stall_req  (stall_req),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; applies start for one cycle and watches 40 cycles.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int stalls,
                         output int dones, output logic [31:0] rlo,
                         output logic [31:0] rhi, output logic rdbz);
    lat = -1; stalls = 0; dones = 0; rlo = '0; rhi = '0; rdbz = 1'b0;
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (stall_req) stalls++;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = cyc; rlo = lo; rhi = hi; rdbz = div_by_zero;
        end
      end
      if (cyc == 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  vec_t vecs[9];
  int lat, stalls, dones;
  logic [31:0] rlo, rhi;
  logic rdbz;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 33};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 33};
    vecs[5] = '{1'b0, 32'h1234,       32'd0,        32'hFFFFFFFF,  32'h1234,     1'b1, 1};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0, 33};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,        1'b0, 33};
    vecs[8] = '{1'b0, 32'd5,          32'd10,       32'd0,         32'd5,        1'b0, 33};

    // Reset state, with start probing the combinational stall path.
    @(negedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_stall_nostart", {31'd0, stall_req}, 32'd0);
    start = 1'b1;
    #1;
    check("rst_stall_start", {31'd0, stall_req}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_div($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              lat, stalls, dones, rlo, rhi, rdbz);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].exp_lat);
      check($sformatf("v%0d_done_pulses", i), dones, 1);
      check($sformatf("v%0d_lo", i), rlo, vecs[i].exp_lo);
      check($sformatf("v%0d_hi", i), rhi, vecs[i].exp_hi);
      check($sformatf("v%0d_dbz", i), {31'd0, rdbz}, {31'd0, vecs[i].exp_dbz});
      check($sformatf("v%0d_lo_held", i), lo, vecs[i].exp_lo);
    end

    // Prior result 14/2, then cancel at the 10th CALC cycle of another 100/7.
    run_div("pre", 1'b0, 32'd100, 32'd7, lat, stalls, dones, rlo, rhi, rdbz);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 0; c < 10; c++) @(negedge clk);
    start = 1'b0;
    cancel = 1'b1;
    #1;
    check("cancel_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_no_done", {31'd0, done}, 32'd0);
    check("cancel_hi", hi, 32'd2);
    check("cancel_lo", lo, 32'd14);
    check("cancel_idle_stall", {31'd0, stall_req}, 32'd0);
    run_div("post_cancel", 1'b0, 32'd45, 32'd6, lat, stalls, dones, rlo, rhi, rdbz);
    check("post_cancel_latency", lat, 33);
    check("post_cancel_lo", rlo, 32'd7);
    check("post_cancel_hi", rhi, 32'd3);

    // cancel overrides start in IDLE.
    is_signed = 1'b0; dividend = 32'd9; divisor = 32'd0; start = 1'b1; cancel = 1'b1;
    #1;
    check("cancel_over_start_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    check("cancel_over_start_done", {31'd0, done}, 32'd0);
    check("cancel_over_start_hi", hi, 32'd3);

    // Reset mid-CALC, start held across release.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("midrst_stall_start", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst", 1'b0, 32'd1000, 32'd33, lat, stalls, dones, rlo, rhi, rdbz);
    check("after_rst_latency", lat, 33);
    check("after_rst_lo", rlo, 32'd30);
    check("after_rst_hi", rhi, 32'd10);

    // Start held continuously: ignored in DONE, re-accepted the cycle after.
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 0; c < 33; c++) @(negedge clk);
    #1;
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_done_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    #1;
    check("b2b_next_done", {31'd0, done}, 32'd0);
    check("b2b_next_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("b2b_calc_stall", {31'd0, stall_req}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
